// File: rtl/cache_sa_wb.sv
`default_nettype none
// ============================================================================
// Module      : cache_sa_wb
// Description : Set-associative write-back / write-allocate cache with per-set
//               LRU and burst writeback. Optional CACHE_STATS_EN adds counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_sa_wb #(
    parameter int ADDR_SZ   = 10,
    parameter int DATA_SZ   = 32,
    parameter int WAYS      = 2,
    parameter int SETS      = 4,
    parameter int BLK_WORDS = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_SZ-1:0] cpu_addr,
    input  logic [DATA_SZ-1:0] cpu_wdata,
    output logic [DATA_SZ-1:0] cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_hit,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_SZ-1:0] mem_addr,
    output logic [DATA_SZ-1:0] mem_wdata,
    input  logic [DATA_SZ-1:0] mem_rdata,
    input  logic               mem_done
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt,
    output logic [15:0]        wb_cnt
`endif
);

    localparam int c_WORD_W = $clog2(BLK_WORDS);
    localparam int c_IDX_W  = $clog2(SETS);
    localparam int c_TAG_W  = ADDR_SZ - 2 - c_WORD_W - c_IDX_W;
    localparam int c_WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOOKUP = 3'd1;
    localparam logic [2:0] c_RESP   = 3'd2;
    localparam logic [2:0] c_WB     = 3'd3;
    localparam logic [2:0] c_FILL   = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;

    logic                r_we;
    logic [ADDR_SZ-1:0]  r_addr;
    logic [DATA_SZ-1:0]  r_wdata;
    logic                r_missed;
    logic [c_WAY_W-1:0]  r_victim;
    logic [c_WORD_W-1:0] r_beat;
    logic [DATA_SZ-1:0]  r_rdata;

    logic [WAYS-1:0]     r_valid [SETS];
    logic [WAYS-1:0]     r_dirty [SETS];
    logic [SETS-1:0]     r_lru;
    logic [c_TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [DATA_SZ-1:0]  r_data  [WAYS][SETS][BLK_WORDS];

    logic [1:0]          w_off;
    logic [c_WORD_W-1:0] w_word;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic                w_hit;
    logic [c_WAY_W-1:0]  w_hit_way;
    logic [c_WAY_W-1:0]  w_victim;
    logic                w_victim_dirty;
    logic                w_last_beat;
    logic [DATA_SZ-1:0]  w_hit_word;
    logic [7:0]          w_byte;
    logic [DATA_SZ-1:0]  w_byte_rd;
    logic [DATA_SZ-1:0]  w_wr_word;

    assign w_off       = r_addr[1:0];
    assign w_word      = r_addr[2 +: c_WORD_W];
    assign w_idx       = r_addr[2 + c_WORD_W +: c_IDX_W];
    assign w_tag       = r_addr[ADDR_SZ-1 -: c_TAG_W];
    assign w_last_beat = (r_beat == c_WORD_W'(BLK_WORDS - 1));

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_WAY_W'(w);
            end
        end
    end

    // Lowest-index invalid way wins; otherwise the way the LRU bit points at.
    always_comb begin
        w_victim = (WAYS > 1) ? c_WAY_W'(r_lru[w_idx]) : '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_victim = c_WAY_W'(w);
            end
        end
    end

    assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
    assign w_hit_word     = r_data[w_hit_way][w_idx][w_word];
    assign w_byte         = w_hit_word[{w_off, 3'b000} +: 8];
    assign w_byte_rd      = {{(DATA_SZ - 8){w_byte[7]}}, w_byte};

    always_comb begin
        w_wr_word = r_wdata;
        if (w_off != 2'b00) begin
            w_wr_word                      = w_hit_word;
            w_wr_word[{w_off, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (cpu_req) w_next_state = c_LOOKUP;
            c_LOOKUP: begin
                if (w_hit)               w_next_state = c_RESP;
                else if (w_victim_dirty) w_next_state = c_WB;
                else                     w_next_state = c_FILL;
            end
            c_WB:     if (mem_done && w_last_beat) w_next_state = c_FILL;
            c_FILL:   if (mem_done && w_last_beat) w_next_state = c_LOOKUP;
            c_RESP:   w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = 1'b0;
        cpu_hit   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            c_RESP: begin
                cpu_ready = 1'b1;
                cpu_hit   = !r_missed;
            end
            c_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[r_victim][w_idx], w_idx, r_beat, 2'b00};
                mem_wdata = r_data[r_victim][w_idx][r_beat];
            end
            c_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, r_beat, 2'b00};
            end
            default: ;
        endcase
    end

    assign cpu_rdata = r_rdata;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_missed <= 1'b0;
            r_victim <= '0;
            r_beat   <= '0;
            r_rdata  <= '0;
            r_lru    <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cpu_req) begin
                        r_we     <= cpu_we;
                        r_addr   <= cpu_addr;
                        r_wdata  <= cpu_wdata;
                        r_missed <= 1'b0;
                    end
                end
                c_LOOKUP: begin
                    if (w_hit) begin
                        if (r_we) begin
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                        end else begin
                            r_rdata <= (w_off == 2'b00) ? w_hit_word : w_byte_rd;
                        end
                        if (WAYS > 1) begin
                            r_lru[w_idx] <= ~w_hit_way[0];
                        end
                    end else begin
                        r_missed <= 1'b1;
                        r_victim <= w_victim;
                        r_beat   <= '0;
                    end
                end
                c_WB: begin
                    if (mem_done) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            r_dirty[w_idx][r_victim] <= 1'b0;
                        end
                    end
                end
                c_FILL: begin
                    if (mem_done) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            r_valid[w_idx][r_victim] <= 1'b1;
                            r_dirty[w_idx][r_victim] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage arrays keep their contents across reset; only valid bits gate them.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if ((r_state == c_LOOKUP) && w_hit && r_we) begin
                r_data[w_hit_way][w_idx][w_word] <= w_wr_word;
            end
            if ((r_state == c_FILL) && mem_done) begin
                r_data[r_victim][w_idx][r_beat] <= mem_rdata;
                if (w_last_beat) begin
                    r_tag[r_victim][w_idx] <= w_tag;
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;
    logic [15:0] r_wb_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if ((r_state == c_LOOKUP) && !r_missed) begin
                if (w_hit && (r_hit_cnt != 16'hFFFF))    r_hit_cnt  <= r_hit_cnt + 16'd1;
                if (!w_hit && (r_miss_cnt != 16'hFFFF))  r_miss_cnt <= r_miss_cnt + 16'd1;
            end
            if ((r_state == c_WB) && mem_done && w_last_beat && (r_wb_cnt != 16'hFFFF)) begin
                r_wb_cnt <= r_wb_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
    assign wb_cnt   = r_wb_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_sa_wb.sv
`default_nettype none
// Testbench for cache_sa_wb: directed scenarios plus random traffic checked against
// a behavioural model (flat byte memory + per-set resident tags ordered by last use).
module tb_cache_sa_wb;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_hit;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_done  = 1'b0;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic [15:0] wb_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    cache_sa_wb dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_hit   (cpu_hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .wb_cnt    (wb_cnt)
`endif
    );

    // Main memory: answers each beat one cycle after it is requested.
    logic [7:0]  mem_b [1024];
    logic [9:0]  log_addr [$];
    logic        log_we   [$];
    logic [31:0] log_data [$];

    always @(posedge clock) begin
        if (mem_req && !mem_done) begin
            mem_done <= 1'b1;
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_data.push_back(mem_wdata);
            if (mem_we) begin
                for (int k = 0; k < 4; k++) mem_b[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
            end else begin
                mem_rdata <= {mem_b[int'(mem_addr) + 3], mem_b[int'(mem_addr) + 2],
                              mem_b[int'(mem_addr) + 1], mem_b[int'(mem_addr)]};
            end
        end else begin
            mem_done <= 1'b0;
        end
    end

    // Reference model
    logic [7:0]  truth_b [1024];
    bit          m_vld [4][2];
    bit          m_dty [4][2];
    int          m_tag [4][2];
    int          m_age [4][2];
    int          m_time;
    int          exp_hits, exp_miss, exp_wbs;
    logic [9:0]  exp_addr [$];
    logic        exp_we   [$];
    logic [31:0] exp_data [$];

    function automatic logic [31:0] truth_word(input int a);
        return {truth_b[a + 3], truth_b[a + 2], truth_b[a + 1], truth_b[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) truth_b[i] = mem_b[i];
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++) begin
                m_vld[s][w] = 1'b0;
                m_dty[s][w] = 1'b0;
                m_age[s][w] = 0;
            end
        m_time = 0; exp_hits = 0; exp_miss = 0; exp_wbs = 0;
    endtask

    task automatic model_req(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                             output logic hit, output logic [31:0] rd);
        int s, t, way, a;
        logic [7:0] b;
        s = int'(addr[5:4]);
        t = int'(addr[9:6]);
        a = int'(addr);
        way = -1;
        exp_addr.delete(); exp_we.delete(); exp_data.delete();
        for (int w = 0; w < 2; w++) if (m_vld[s][w] && m_tag[s][w] == t) way = w;
        hit = (way >= 0);
        if (way < 0) begin
            exp_miss++;
            if (!m_vld[s][0])      way = 0;
            else if (!m_vld[s][1]) way = 1;
            else                   way = (m_age[s][0] < m_age[s][1]) ? 0 : 1;
            if (m_vld[s][way] && m_dty[s][way]) begin
                exp_wbs++;
                for (int bt = 0; bt < 4; bt++) begin
                    exp_addr.push_back(10'(m_tag[s][way] * 64 + s * 16 + bt * 4));
                    exp_we.push_back(1'b1);
                    exp_data.push_back(truth_word(m_tag[s][way] * 64 + s * 16 + bt * 4));
                end
            end
            for (int bt = 0; bt < 4; bt++) begin
                exp_addr.push_back(10'(t * 64 + s * 16 + bt * 4));
                exp_we.push_back(1'b0);
                exp_data.push_back(32'h0);
            end
            m_vld[s][way] = 1'b1;
            m_tag[s][way] = t;
            m_dty[s][way] = 1'b0;
        end else begin
            exp_hits++;
        end
        m_time++;
        m_age[s][way] = m_time;
        if (we) begin
            m_dty[s][way] = 1'b1;
            if (addr[1:0] != 2'b00) truth_b[a] = wdata[7:0];
            else for (int k = 0; k < 4; k++) truth_b[a + k] = wdata[8*k +: 8];
        end
        b  = truth_b[a];
        rd = (addr[1:0] != 2'b00) ? {{24{b[7]}}, b} : truth_word(a);
    endtask

    // Drives one CPU request; cpu_* inputs are scrambled once the request is accepted.
    task automatic do_req(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                          output logic hit, output logic [31:0] rd, output int lat, output logic pulse_ok);
        @(negedge clock);
        log_addr.delete(); log_we.delete(); log_data.delete();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(negedge clock);
        cpu_we = 1'($urandom); cpu_addr = 10'($urandom); cpu_wdata = $urandom;
        lat = 1;
        while (!cpu_ready && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        hit = cpu_hit;
        rd  = cpu_rdata;
        cpu_req = 1'b0;
        @(negedge clock);
        pulse_ok = !cpu_ready;
    endtask

    task automatic access(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                          output logic eh, output logic [31:0] ed, output logic oh,
                          output logic [31:0] od, output int lat, output logic pok);
        model_req(we, addr, wdata, eh, ed);
        do_req(we, addr, wdata, oh, od, lat, pok);
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        reset_n = 1'b0; cpu_req = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({cpu_ready, cpu_hit, mem_req, mem_we} !== 4'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {cpu_ready, cpu_hit, mem_req, mem_we});
        end
        n_cmp++;
        if (cpu_rdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata);
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== 42'h0) begin
            n_bad++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        model_reset();
    endtask

    task automatic test_cold_read();
        logic eh, oh, pok; logic [31:0] ed, od; int lat;
        access(1'b0, 10'h000, 32'h0, eh, ed, oh, od, lat, pok);
        n_cmp++;
        if (oh !== 1'b0 || od !== 32'h03020100) begin
            n_bad++; $display("FAIL cold_read: got hit=%b data=%h want hit=0 data=03020100", oh, od);
        end
        n_cmp++;
        if (log_addr.size() != 4) begin
            n_bad++; $display("FAIL cold_beats: got %0d beats want 4", log_addr.size());
        end else begin
            for (int b = 0; b < 4; b++) begin
                n_cmp++;
                if (log_addr[b] !== 10'(b * 4) || log_we[b] !== 1'b0) begin
                    n_bad++; $display("FAIL cold_beat%0d: got addr=%h we=%b want addr=%h we=0", b, log_addr[b], log_we[b], 10'(b * 4));
                end
            end
        end
    endtask

    task automatic test_write_alloc();
        logic eh, oh, pok; logic [31:0] ed, od; int lat;
        access(1'b1, 10'h010, 32'h00000FAC, eh, ed, oh, od, lat, pok);
        n_cmp++;
        if (oh !== 1'b0 || log_addr.size() != 4) begin
            n_bad++; $display("FAIL wr_alloc_miss: got hit=%b beats=%0d want hit=0 beats=4", oh, log_addr.size());
        end
        access(1'b0, 10'h014, 32'h0, eh, ed, oh, od, lat, pok);
        n_cmp++;
        if (oh !== 1'b1 || od !== 32'h17161514 || lat != 2) begin
            n_bad++; $display("FAIL rd_014: got hit=%b data=%h lat=%0d want hit=1 data=17161514 lat=2", oh, od, lat);
        end
        access(1'b0, 10'h010, 32'h0, eh, ed, oh, od, lat, pok);
        n_cmp++;
        if (oh !== 1'b1 || od !== 32'h00000FAC || !pok) begin
            n_bad++; $display("FAIL rd_010: got hit=%b data=%h pulse_ok=%b want hit=1 data=00000fac pulse_ok=1", oh, od, pok);
        end
    endtask

    task automatic test_byte();
        logic eh, oh, pok; logic [31:0] ed, od; int lat;
        access(1'b0, 10'h080, 32'h0, eh, ed, oh, od, lat, pok);
        access(1'b0, 10'h086, 32'h0, eh, ed, oh, od, lat, pok);
        n_cmp++;
        if (oh !== 1'b1 || od !== 32'hFFFFFF86) begin
            n_bad++; $display("FAIL byte_rd_086: got hit=%b data=%h want hit=1 data=ffffff86", oh, od);
        end
        access(1'b1, 10'h042, 32'hAAAAAA3F, eh, ed, oh, od, lat, pok);
        access(1'b0, 10'h040, 32'h0, eh, ed, oh, od, lat, pok);
        n_cmp++;
        if (oh !== 1'b1 || od !== 32'h433F4140) begin
            n_bad++; $display("FAIL byte_wr_042: got hit=%b data=%h want hit=1 data=433f4140", oh, od);
        end
    endtask

    task automatic test_lru_wb();
        logic eh, oh, pok; logic [31:0] ed, od, want; int lat;
        reset_pulse();
        access(1'b0, 10'h000, 32'h0, eh, ed, oh, od, lat, pok);
        access(1'b0, 10'h100, 32'h0, eh, ed, oh, od, lat, pok);
        access(1'b1, 10'h000, 32'hDEADBEEF, eh, ed, oh, od, lat, pok);
        access(1'b0, 10'h100, 32'h0, eh, ed, oh, od, lat, pok);
        access(1'b0, 10'h200, 32'h0, eh, ed, oh, od, lat, pok);
        n_cmp++;
        if (oh !== 1'b0 || od !== 32'h03020100) begin
            n_bad++; $display("FAIL lru_rd_200: got hit=%b data=%h want hit=0 data=03020100", oh, od);
        end
        n_cmp++;
        if (log_addr.size() != 8) begin
            n_bad++; $display("FAIL lru_beats: got %0d beats want 8", log_addr.size());
        end else begin
            for (int b = 0; b < 4; b++) begin
                want = (b == 0) ? 32'hDEADBEEF : {8'(4*b + 3), 8'(4*b + 2), 8'(4*b + 1), 8'(4*b)};
                n_cmp++;
                if (log_addr[b] !== 10'(4 * b) || log_we[b] !== 1'b1 || log_data[b] !== want) begin
                    n_bad++; $display("FAIL lru_wb%0d: got addr=%h we=%b data=%h want addr=%h we=1 data=%h",
                                      b, log_addr[b], log_we[b], log_data[b], 10'(4 * b), want);
                end
                n_cmp++;
                if (log_addr[b + 4] !== 10'(10'h200 + 4 * b) || log_we[b + 4] !== 1'b0) begin
                    n_bad++; $display("FAIL lru_fill%0d: got addr=%h we=%b want addr=%h we=0",
                                      b, log_addr[b + 4], log_we[b + 4], 10'(10'h200 + 4 * b));
                end
            end
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        n_cmp++;
        if (hit_cnt !== 16'(exp_hits) || miss_cnt !== 16'(exp_miss) || wb_cnt !== 16'(exp_wbs)) begin
            n_bad++; $display("FAIL stats: got h=%0d m=%0d wb=%0d want h=%0d m=%0d wb=%0d",
                              hit_cnt, miss_cnt, wb_cnt, exp_hits, exp_miss, exp_wbs);
        end
        n_cmp++;
        if (wb_cnt !== 16'd1) begin
            n_bad++; $display("FAIL stats_wb: got %0d want 1", wb_cnt);
        end
    endtask
`endif

    task automatic test_reset_mid_wb();
        logic eh, oh, pok, found; logic [31:0] ed, od; int lat;
        reset_pulse();
        access(1'b1, 10'h000, 32'hCAFEF00D, eh, ed, oh, od, lat, pok);
        access(1'b0, 10'h100, 32'h0, eh, ed, oh, od, lat, pok);
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h200; cpu_wdata = 32'h0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            if (mem_req && mem_we && mem_addr == 10'h008) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL midwb_beat2: got timeout want writeback beat at 008");
        end
        reset_n = 1'b0; cpu_req = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            n_bad++; $display("FAIL midwb_drop: got mem_req=%b cpu_ready=%b want 0/0", mem_req, cpu_ready);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        model_reset();
        access(1'b0, 10'h000, 32'h0, eh, ed, oh, od, lat, pok);
        n_cmp++;
        if (oh !== 1'b0 || od !== ed) begin
            n_bad++; $display("FAIL midwb_reread: got hit=%b data=%h want hit=0 data=%h", oh, od, ed);
        end
        access(1'b0, 10'h100, 32'h0, eh, ed, oh, od, lat, pok);
        n_cmp++;
        if (oh !== 1'b0 || od !== ed) begin
            n_bad++; $display("FAIL midwb_invalid: got hit=%b data=%h want hit=0 data=%h", oh, od, ed);
        end
    endtask

    task automatic test_random(input int n);
        logic eh, oh, pok, we; logic [31:0] ed, od, wd; logic [9:0] addr; int lat;
        for (int i = 0; i < n; i++) begin
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            addr = 10'($urandom_range(0, 3) * 64 + $urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4);
            if ($urandom_range(0, 2) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            access(we, addr, wd, eh, ed, oh, od, lat, pok);
            n_cmp++;
            if (lat >= 200) begin
                n_bad++; $display("FAIL rnd%0d_timeout: got no cpu_ready in %0d cycles want completion", i, lat);
            end
            n_cmp++;
            if (oh !== eh || (eh && lat != 2) || !pok) begin
                n_bad++; $display("FAIL rnd%0d_hit: got hit=%b lat=%0d pulse_ok=%b want hit=%b", i, oh, lat, pok, eh);
            end
            if (!we) begin
                n_cmp++;
                if (od !== ed) begin
                    n_bad++; $display("FAIL rnd%0d_rdata addr=%h: got %h want %h", i, addr, od, ed);
                end
            end
            n_cmp++;
            if (log_addr.size() != exp_addr.size()) begin
                n_bad++; $display("FAIL rnd%0d_beats: got %0d want %0d", i, log_addr.size(), exp_addr.size());
            end else begin
                for (int b = 0; b < exp_addr.size(); b++) begin
                    n_cmp++;
                    if (log_addr[b] !== exp_addr[b] || log_we[b] !== exp_we[b] ||
                        (exp_we[b] && log_data[b] !== exp_data[b])) begin
                        n_bad++; $display("FAIL rnd%0d_beat%0d: got %h/%b/%h want %h/%b/%h", i, b,
                                          log_addr[b], log_we[b], log_data[b], exp_addr[b], exp_we[b], exp_data[b]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'(i);
        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        test_reset();
        test_cold_read();
        test_write_alloc();
        test_byte();
        test_lru_wb();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        test_reset_mid_wb();
        test_random(80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
